sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO and the next generation of the team's 8-entry synchronous FIFO. It adds configurable data width and depth, an asynchronous reset, an occupancy count and almost-full/almost-empty thresholds. It also adds sticky overflow/underflow error flags and a read-data valid strobe. It sits between a producer and a consumer in the same clock domain, for example between a byte-stream front end and a packet parser.

---
 rtl/sync_fifo_param.sv | 99 +++++++++
 tb/tb_sync_fifo_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with occupancy, thresholds and sticky error flags
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   w_ptr;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status is derived straight from the registered pointers so it never lags them.
  always_comb begin
    count        = w_ptr - r_ptr;
    empty        = (w_ptr == r_ptr);
    full         = (w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0]) &&
                   (w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH]);
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
    wr_acc       = w_en && !full;
    rd_acc       = r_en && !empty;
  end

  // Storage array carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[w_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_acc) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (rd_acc) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[r_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  // A set in the same cycle as err_clr takes priority so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [7:0] a_din, a_dout;
  logic       a_wen, a_ren, a_clr, a_dv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [3:0] a_cnt;

  sync_fifo_param u_fifo_a (
    .clk(clk), .rst(rst), .data_in(a_din), .w_en(a_wen), .r_en(a_ren), .err_clr(a_clr),
    .data_out(a_dout), .data_valid(a_dv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt), .overflow(a_ov), .underflow(a_un)
  );

  // Wide/deep instance with thresholds at the extremes
  logic [15:0] b_din, b_dout;
  logic        b_wen, b_ren, b_clr, b_dv, b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [4:0]  b_cnt;

  sync_fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AF_THRESH(16), .AE_THRESH(0)) u_fifo_b (
    .clk(clk), .rst(rst), .data_in(b_din), .w_en(b_wen), .r_en(b_ren), .err_clr(b_clr),
    .data_out(b_dout), .data_valid(b_dv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt), .overflow(b_ov), .underflow(b_un)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_byte;

  initial begin
    rst = 1'b1;
    a_din = '0; a_wen = 0; a_ren = 0; a_clr = 0;
    b_din = '0; b_wen = 0; b_ren = 0; b_clr = 0;
    tick(); tick();
    rst = 1'b0;

    check("rst_count", a_cnt, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_ae", a_ae, 1);
    check("rst_af", a_af, 0);
    check("rst_dv", a_dv, 0);
    check("rst_dout", a_dout, 0);
    check("rst_ov", a_ov, 0);
    check("rst_un", a_un, 0);

    // Fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      a_wen = 1; a_din = 8'(i);
      tick();
      check("fill_count", a_cnt, i);
      check("fill_af", a_af, (i >= 6) ? 1 : 0);
      check("fill_ae", a_ae, (i <= 2) ? 1 : 0);
      check("fill_full", a_full, (i == 8) ? 1 : 0);
    end
    a_din = 8'h99;
    tick();
    check("ovf_flag", a_ov, 1);
    check("ovf_count", a_cnt, 8);

    // Simultaneous access while full: read wins, 0xAA dropped
    a_wen = 1; a_ren = 1; a_din = 8'hAA;
    tick();
    check("full_rw_count", a_cnt, 7);
    check("full_rw_ov", a_ov, 1);
    check("full_rw_dv", a_dv, 1);
    check("full_rw_dout", a_dout, 8'h01);
    a_wen = 0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("drain_dout", a_dout, i);
      check("drain_dv", a_dv, 1);
      check("drain_count", a_cnt, 8 - i);
    end
    check("drain_empty", a_empty, 1);
    a_ren = 0;
    tick();
    check("idle_dv", a_dv, 0);
    check("idle_dout_hold", a_dout, 8'h08);

    a_clr = 1;
    tick();
    a_clr = 0;
    check("clr_ov", a_ov, 0);
    check("clr_un", a_un, 0);

    // Simultaneous access while empty: write only, no fall-through
    a_wen = 1; a_ren = 1; a_din = 8'h55;
    tick();
    check("empty_rw_count", a_cnt, 1);
    check("empty_rw_un", a_un, 1);
    check("empty_rw_dv", a_dv, 0);
    a_wen = 0;
    tick();
    check("empty_rw_dout", a_dout, 8'h55);
    check("empty_rw_dv2", a_dv, 1);
    check("empty_rw_empty", a_empty, 1);

    // Set beats clear in the same cycle
    a_ren = 1; a_clr = 1;
    tick();
    check("set_wins_un", a_un, 1);
    a_ren = 0;
    tick();
    a_clr = 0;
    check("clr2_un", a_un, 0);

    // Wrap/throughput at constant occupancy 3
    for (int i = 0; i < 3; i++) begin
      a_wen = 1; a_din = 8'(8'h10 + i);
      q.push_back(a_din);
      tick();
    end
    check("pre_wrap_count", a_cnt, 3);
    a_ren = 1;
    for (int k = 0; k < 40; k++) begin
      a_din = 8'(8'h13 + k);
      exp_byte = q.pop_front();
      q.push_back(a_din);
      tick();
      check("wrap_dout", a_dout, exp_byte);
      check("wrap_count", a_cnt, 3);
    end
    a_ren = 0;
    check("wrap_ov", a_ov, 0);
    check("wrap_un", a_un, 0);

    // Asynchronous reset with 5 entries stored
    a_din = 8'h77; tick();
    a_din = 8'h78; tick();
    a_wen = 0;
    check("pre_rst_count", a_cnt, 5);
    #2 rst = 1'b1;
    #1;
    check("arst_count", a_cnt, 0);
    check("arst_empty", a_empty, 1);
    check("arst_ae", a_ae, 1);
    check("arst_dv", a_dv, 0);
    check("arst_dout", a_dout, 0);
    tick();
    rst = 1'b0;
    a_ren = 1;
    tick();
    a_ren = 0;
    check("post_rst_un", a_un, 1);
    check("post_rst_dv", a_dv, 0);
    check("post_rst_count", a_cnt, 0);

    // Wide/deep instance: 16 entries, thresholds coincide with full/empty
    check("b_rst_ae", b_ae, 1);
    check("b_rst_empty", b_empty, 1);
    for (int i = 1; i <= 16; i++) begin
      b_wen = 1; b_din = 16'(16'hA500 + i);
      tick();
      check("b_fill_count", b_cnt, i);
      check("b_fill_full", b_full, (i == 16) ? 1 : 0);
      check("b_fill_af", b_af, (i == 16) ? 1 : 0);
      check("b_fill_ae", b_ae, 0);
    end
    tick();
    b_wen = 0;
    check("b_ovf", b_ov, 1);
    check("b_ovf_count", b_cnt, 16);
    b_ren = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("b_drain_dout", b_dout, 16'hA500 + i);
      check("b_drain_empty", b_empty, (i == 16) ? 1 : 0);
      check("b_drain_ae", b_ae, (i == 16) ? 1 : 0);
    end
    b_ren = 0;
    b_clr = 1;
    tick();
    b_clr = 0;
    check("b_clr_ov", b_ov, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
